// File: rtl/step_gen.sv
// step_gen: debounced pushbutton to single-step pulse generator with
// optional auto-repeat. Each accepted step captures the switch operand and
// function select and bumps a wrapping step counter.
//
// Handshake: there is no backpressure. step is a one-cycle strobe. When it is
// high, op_a/op_sel/step_count already carry the values captured on the same
// edge, and they stay stable until the next step.
module step_gen #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       key_n,
  input  logic       repeat_en,
  input  logic [7:0] sw_data,
  input  logic [2:0] sw_op,
  output logic       step,
  output logic [7:0] op_a,
  output logic [2:0] op_sel,
  output logic       key_state,
  output logic [7:0] step_count,
  output logic [2:0] state_dbg
);

  // The counter must reach the largest terminal value of the three timers.
  localparam int CNT_MAX_A = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int CNT_MAX   = (CNT_MAX_A > REPEAT_PERIOD) ? CNT_MAX_A : REPEAT_PERIOD;
  localparam int CW        = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_PRESS_DB   = 3'd1,
    S_HELD       = 3'd2,
    S_REPEAT     = 3'd3,
    S_RELEASE_DB = 3'd4
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          sync1;
  logic          sync2;
  logic          pressed;
  logic          issue;

  // Two-flop synchronizer; idles at 1 (released) so reset never looks like a press.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  // The only view of the key that the rest of the block uses.
  assign pressed = ~sync2;

  // State and shared cycle counter register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state, counter and step-issue decisions; the counter restarts on every state change.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    issue      = 1'b0;
    case (state)
      S_IDLE: begin
        if (pressed) state_next = S_PRESS_DB;
      end
      S_PRESS_DB: begin
        if (!pressed) begin
          state_next = S_IDLE;
        end else if (cnt == DB_LAST) begin
          state_next = S_HELD;
          issue      = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      S_HELD: begin
        if (!pressed) begin
          state_next = S_RELEASE_DB;
        end else if (repeat_en && (cnt == RD_LAST)) begin
          state_next = S_REPEAT;
          issue      = 1'b1;
        end else if (cnt != RD_LAST) begin
          // Saturates at the delay terminal value while repeat is disabled.
          cnt_next = cnt + 1'b1;
        end
      end
      S_REPEAT: begin
        if (!pressed) begin
          state_next = S_RELEASE_DB;
        end else if (!repeat_en) begin
          state_next = S_HELD;
        end else if (cnt == RP_LAST) begin
          issue    = 1'b1;
          cnt_next = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      S_RELEASE_DB: begin
        if (pressed) begin
          // A bounce during release goes back to holding without a step.
          state_next = S_HELD;
        end else if (cnt == DB_LAST) begin
          state_next = S_IDLE;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
    if (state_next != state) cnt_next = '0;
  end

  // Step strobe and operand capture; the captured values hold between steps.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      step       <= 1'b0;
      op_a       <= 8'h00;
      op_sel     <= 3'd0;
      step_count <= 8'h00;
    end else begin
      step <= issue;
      if (issue) begin
        op_a       <= sw_data;
        op_sel     <= sw_op;
        step_count <= step_count + 8'd1;
      end
    end
  end

  // The debounced level counts as pressed from acceptance until the release is accepted.
  assign key_state = (state == S_HELD) || (state == S_REPEAT) || (state == S_RELEASE_DB);
  assign state_dbg = state;

endmodule

// File: tb/tb_step_gen.sv
// tb_step_gen: directed scenarios followed by randomized key activity. A
// behavioural model predicts every step and the debounced level, and a monitor
// compares those predictions with the outputs of step_gen.
module tb_step_gen;

  localparam int D  = 4;
  localparam int RD = 8;
  localparam int RP = 3;

  logic       clock     = 1'b0;
  logic       resetn    = 1'b1;
  logic       key_n     = 1'b1;
  logic       repeat_en = 1'b0;
  logic [7:0] sw_data   = 8'h00;
  logic [2:0] sw_op     = 3'd0;
  logic       step;
  logic [7:0] op_a;
  logic [2:0] op_sel;
  logic       key_state;
  logic [7:0] step_count;
  logic [2:0] state_dbg;

  int checks = 0;
  int errors = 0;

  // Expected step payload: {op_a, op_sel, step_count}.
  logic [18:0] exp_q[$];

  // Behavioural model state.
  logic       m1, m2, smp;
  logic       deb;
  logic       releasing;
  int         run;
  int         hold_age;
  logic [7:0] mcount;

  step_gen #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clock(clock),
    .resetn(resetn),
    .key_n(key_n),
    .repeat_en(repeat_en),
    .sw_data(sw_data),
    .sw_op(sw_op),
    .step(step),
    .op_a(op_a),
    .op_sel(op_sel),
    .key_state(key_state),
    .step_count(step_count),
    .state_dbg(state_dbg)
  );

  // Clock
  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the key is seen two edges late. A press or release is
  // accepted after D+1 consecutive agreeing samples. While held, the repeat
  // steps fall at hold ages RD, RD+RP, RD+2*RP, ...
  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m1 = 1'b1; m2 = 1'b1; deb = 1'b0; releasing = 1'b0;
      run = 0; hold_age = 0; mcount = 8'h00;
      exp_q.delete();
    end else begin
      smp = m2;
      m2  = m1;
      m1  = key_n;
      if (!deb) begin
        if (!smp) begin
          run++;
          if (run == D + 1) begin
            deb = 1'b1; run = 0; hold_age = 0; releasing = 1'b0;
            mcount = mcount + 8'd1;
            exp_q.push_back({sw_data, sw_op, mcount});
          end
        end else begin
          run = 0;
        end
      end else begin
        if (smp) begin
          releasing = 1'b1;
          run++;
          if (run == D + 1) begin
            deb = 1'b0; run = 0; releasing = 1'b0;
          end
        end else if (releasing) begin
          releasing = 1'b0; run = 0; hold_age = 0;
        end else begin
          hold_age++;
          if (repeat_en && hold_age >= RD && ((hold_age - RD) % RP) == 0) begin
            mcount = mcount + 8'd1;
            exp_q.push_back({sw_data, sw_op, mcount});
          end
        end
      end
    end
  end

  // Monitor: samples on the falling edge, pops expected steps and checks the debounced level.
  always @(negedge clock) begin
    logic [18:0] e;
    if (resetn) begin
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (!step) begin
          errors++;
          $display("FAIL step_missing: step=%0b expected 1 at %0t", step, $time);
        end else if ({op_a, op_sel, step_count} !== e) begin
          errors++;
          $display("FAIL step_payload: op_a=%02h op_sel=%0d count=%0d expected op_a=%02h op_sel=%0d count=%0d",
                   op_a, op_sel, step_count, e[18:11], e[10:8], e[7:0]);
        end
      end else if (step) begin
        checks++;
        errors++;
        $display("FAIL step_unexpected: step=1 expected 0 at %0t", $time);
      end
      check("key_state", int'(key_state), int'(deb));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Counts falling edges until the first step; k = -1 if none is seen within the limit.
  task automatic wait_first_step(input int limit, output int k);
    k = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clock);
      if (step && k < 0) k = i;
      if (k >= 0) break;
    end
  endtask

  task automatic count_steps(input int n, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (step) c++;
    end
  endtask

  task automatic async_reset_check(input string tag);
    @(posedge clock);
    #2 resetn = 1'b0;
    #1;
    check({tag, "_step"},  int'(step), 0);
    check({tag, "_op_a"},  int'(op_a), 0);
    check({tag, "_op_sel"}, int'(op_sel), 0);
    check({tag, "_key_state"}, int'(key_state), 0);
    check({tag, "_count"}, int'(step_count), 0);
    @(negedge clock);
    resetn = 1'b1;
  endtask

  initial begin
    int k;
    int c;
    int seen;
    logic [7:0] start_count;

    // Reset
    #1 resetn = 1'b0;
    #1;
    check("rst_step", int'(step), 0);
    check("rst_op_a", int'(op_a), 0);
    check("rst_op_sel", int'(op_sel), 0);
    check("rst_key_state", int'(key_state), 0);
    check("rst_count", int'(step_count), 0);
    cycles(3);
    resetn = 1'b1;
    cycles(2);

    // Clean press: the first step shows up after edge D+3.
    sw_data = 8'h5A; sw_op = 3'd3; repeat_en = 1'b0;
    key_n = 1'b0;
    wait_first_step(30, k);
    check("press_latency", k, D + 3);
    check("press_op_a", int'(op_a), 8'h5A);
    check("press_op_sel", int'(op_sel), 3);
    check("press_count", int'(step_count), 1);
    check("press_key_state", int'(key_state), 1);
    cycles(5);
    key_n = 1'b1;
    cycles(15);
    check("release_key_state", int'(key_state), 0);

    // Bounce: toggling every 2 cycles must never be accepted.
    start_count = step_count;
    for (int i = 0; i < 10; i++) begin
      key_n = ~key_n;
      cycles(2);
    end
    key_n = 1'b1;
    cycles(12);
    check("bounce_count", int'(step_count), int'(start_count));
    check("bounce_key_state", int'(key_state), 0);

    // Hold with repeat: steps at edges 7, 15, 18, 21, 24, 27, 30 of a 30-edge hold.
    repeat_en = 1'b1;
    key_n = 1'b0;
    count_steps(30, c);
    key_n = 1'b1;
    count_steps(12, seen);
    check("repeat_steps", c, 7);
    check("repeat_after_release", seen, 0);
    check("repeat_key_state", int'(key_state), 0);

    // Hold without repeat for 50 cycles: exactly one step.
    repeat_en = 1'b0;
    cycles(2);
    key_n = 1'b0;
    count_steps(50, c);
    key_n = 1'b1;
    count_steps(12, seen);
    check("norepeat_steps", c + seen, 1);

    // Wrap: 256 steps from reset bring the counter back to 0.
    async_reset_check("wrap_rst");
    repeat_en = 1'b1;
    key_n = 1'b0;
    c = 0;
    for (int i = 0; i < 1200 && c < 256; i++) begin
      @(negedge clock);
      if (step) c++;
    end
    check("wrap_steps", c, 256);
    check("wrap_count", int'(step_count), 0);
    key_n = 1'b1;
    cycles(12);

    // Reset in REPEAT at count 7 with the key still held.
    async_reset_check("rep_rst");
    key_n = 1'b0;
    seen = 0;
    for (int i = 0; i < 200 && step_count != 8'd7; i++) @(negedge clock);
    check("rep_count7", int'(step_count), 7);
    async_reset_check("rep_mid");
    wait_first_step(30, k);
    check("rep_post_latency", k, D + 3);
    check("rep_post_count", int'(step_count), 1);
    key_n = 1'b1;
    cycles(12);

    // Randomized key activity; repeat_en only changes while the key is released.
    for (int s = 0; s < 300; s++) begin
      if ($urandom_range(0, 19) == 0) begin
        key_n = 1'b1;
        cycles(D + 6);
        repeat_en = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 39) == 0) async_reset_check("rand_rst");
      key_n = 1'($urandom_range(0, 1));
      c = $urandom_range(1, 30);
      for (int i = 0; i < c; i++) begin
        sw_data = 8'($urandom);
        sw_op   = 3'($urandom);
        @(negedge clock);
      end
    end
    key_n = 1'b1;
    cycles(20);
    check("final_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
